// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: ROM address/data, execute-side stall/branch controls and
// the registered instruction presented to decode.
interface instr_fetch_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 12,
  parameter int OPC_W   = 4
);
  logic [ADDR_W-1:0]        rom_addr;
  logic [INSTR_W-1:0]       rom_data;
  logic                     stall;
  logic                     branch_valid;
  logic [ADDR_W-1:0]        branch_target;
  logic [INSTR_W-1:0]       instr;
  logic [OPC_W-1:0]         opcode;
  logic [INSTR_W-OPC_W-1:0] operand;
  logic [ADDR_W-1:0]        instr_pc;
  logic                     instr_valid;
  logic                     halted;

  modport master (
    output rom_addr, instr, opcode, operand, instr_pc, instr_valid, halted,
    input  rom_data, stall, branch_valid, branch_target
  );

  modport slave (
    input  rom_addr, instr, opcode, operand, instr_pc, instr_valid, halted,
    output rom_data, stall, branch_valid, branch_target
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, registers ROM words, handles stall/branch.
// Optional FETCH_HALT_EN: opcode 0xF stops fetch until reset.
module instr_fetch #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 12,
  parameter int OPC_W   = 4
) (
  input  logic           clk,
  input  logic           rst,
  instr_fetch_if.master  bus
);
  typedef enum logic {S_FETCH, S_HALT} state_t;

  state_t               r_state, w_state_nxt;
  logic [ADDR_W-1:0]    r_pc, w_pc_nxt;
  logic [ADDR_W-1:0]    r_instr_pc, w_instr_pc_nxt;
  logic [INSTR_W-1:0]   r_instr, w_instr_nxt;
  logic                 r_valid, w_valid_nxt;
  logic                 r_halted, w_halted_nxt;
  logic                 w_halt_op;

`ifdef FETCH_HALT_EN
  assign w_halt_op = (bus.rom_data[INSTR_W-1 -: OPC_W] == {OPC_W{1'b1}});
`else
  assign w_halt_op = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_FETCH;
      r_pc       <= '0;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_instr    <= w_instr_nxt;
      r_instr_pc <= w_instr_pc_nxt;
      r_valid    <= w_valid_nxt;
      r_halted   <= w_halted_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_instr_nxt    = r_instr;
    w_instr_pc_nxt = r_instr_pc;
    w_valid_nxt    = r_valid;
    w_halted_nxt   = r_halted;
    case (r_state)
      S_FETCH: begin
        if (bus.branch_valid) begin
          // Flush only: the stale instr/instr_pc stay visible but invalid.
          w_pc_nxt    = bus.branch_target;
          w_valid_nxt = 1'b0;
        end else if (!bus.stall) begin
          w_instr_nxt    = bus.rom_data;
          w_instr_pc_nxt = r_pc;
          w_valid_nxt    = 1'b1;
          if (w_halt_op) w_state_nxt = S_HALT;
          else           w_pc_nxt    = r_pc + 1'b1;
        end
      end
      S_HALT: begin
        w_valid_nxt  = 1'b0;
        w_halted_nxt = 1'b1;
      end
      default: w_state_nxt = S_FETCH;
    endcase
  end

  assign bus.rom_addr    = r_pc;
  assign bus.instr       = r_instr;
  assign bus.opcode      = r_instr[INSTR_W-1 -: OPC_W];
  assign bus.operand     = r_instr[INSTR_W-OPC_W-1:0];
  assign bus.instr_pc    = r_instr_pc;
  assign bus.instr_valid = r_valid;
`ifdef FETCH_HALT_EN
  assign bus.halted      = r_halted;
`else
  assign bus.halted      = 1'b0;
`endif
endmodule
